// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises 128-bit block transfers from the I-cache and the
//               D-cache onto a single slow_memory port. Fixed priority D>I by
//               default; define MEMARB_RR_EN for round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_mem_read_nxt;
    logic              w_mem_write_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_i_ready_nxt;
    logic              w_d_ready_nxt;
    logic [DATA_W-1:0] w_i_rdata_nxt;
    logic [DATA_W-1:0] w_d_rdata_nxt;
    logic              w_d_req;
    logic              w_pick_d;

    assign w_d_req = d_read | d_write;

`ifdef MEMARB_RR_EN
    // Holds which port wins a tie next; the port just granted loses the next tie.
    // Clears to 0 so the I-cache wins the first tie after reset.
    logic r_rr_prio_d;
    logic w_rr_prio_d_nxt;

    assign w_pick_d = w_d_req & (~i_read | r_rr_prio_d);

    always_comb begin
        w_rr_prio_d_nxt = r_rr_prio_d;
        if (r_state == IDLE) begin
            if (w_pick_d) begin
                w_rr_prio_d_nxt = 1'b0;
            end else if (i_read) begin
                w_rr_prio_d_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_prio_d <= 1'b0;
        end else begin
            r_rr_prio_d <= w_rr_prio_d_nxt;
        end
    end
`else
    assign w_pick_d = w_d_req;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_read_nxt  = mem_read;
        w_mem_write_nxt = mem_write;
        w_mem_addr_nxt  = mem_addr;
        w_mem_wdata_nxt = mem_wdata;
        w_i_ready_nxt   = i_ready;
        w_d_ready_nxt   = d_ready;
        w_i_rdata_nxt   = i_rdata;
        w_d_rdata_nxt   = d_rdata;
        case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    // A simultaneous read+write is issued as a write only.
                    w_state_nxt     = GNT_D;
                    w_mem_write_nxt = d_write;
                    w_mem_read_nxt  = ~d_write;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                end else if (i_read) begin
                    w_state_nxt     = GNT_I;
                    w_mem_read_nxt  = 1'b1;
                    w_mem_write_nxt = 1'b0;
                    w_mem_addr_nxt  = i_addr;
                    w_mem_wdata_nxt = '0;
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    w_state_nxt    = RESP;
                    w_mem_read_nxt = 1'b0;
                    w_i_rdata_nxt  = mem_rdata;
                    w_i_ready_nxt  = 1'b1;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    w_state_nxt     = RESP;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_d_rdata_nxt   = mem_write ? '0 : mem_rdata;
                    w_d_ready_nxt   = 1'b1;
                end
            end
            RESP: begin
                // Requests are not sampled here so the winner can drop its request.
                w_state_nxt   = IDLE;
                w_i_ready_nxt = 1'b0;
                w_d_ready_nxt = 1'b0;
                w_i_rdata_nxt = '0;
                w_d_rdata_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            mem_read  <= w_mem_read_nxt;
            mem_write <= w_mem_write_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            i_ready   <= w_i_ready_nxt;
            d_ready   <= w_d_ready_nxt;
            i_rdata   <= w_i_rdata_nxt;
            d_rdata   <= w_d_rdata_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one slow_memory port between the instruction cache (I) and the data cache (D).
- Serialises block transfers: one 128-bit read or write outstanding at a time.
- Holds memory request signals stable until mem_ready, then returns data and a one-cycle ready pulse to the winning requester.
- Sits between the I/D caches and slow_memory at the CHIP top level.

Parameters:
ADDR_W, 28, block address width (matches slow_memory mem_addr)
DATA_W, 128, block data width (matches slow_memory mem_wdata/mem_rdata)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-high reset
i_read  input  1  I-cache block read request; held until i_ready
i_addr  input  ADDR_W  I-cache block address
i_rdata  output  DATA_W  read data to I-cache; valid only while i_ready=1
i_ready  output  1  one-cycle completion pulse to I-cache
d_read  input  1  D-cache block read request; held until d_ready
d_write  input  1  D-cache block write request; held until d_ready
d_addr  input  ADDR_W  D-cache block address
d_wdata  input  DATA_W  D-cache write data
d_rdata  output  DATA_W  read data to D-cache; valid only while d_ready=1
d_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  to slow_memory
mem_write  output  1  to slow_memory
mem_addr  output  ADDR_W  to slow_memory
mem_wdata  output  DATA_W  to slow_memory
mem_rdata  input  DATA_W  from slow_memory; valid only with mem_ready
mem_ready  input  1  from slow_memory; one-cycle pulse

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: all outputs 0; state IDLE; round-robin pointer (if compiled in) = I.
- States:
  - IDLE: no transfer in flight.
  - GNT_I: I-cache transfer in flight.
  - GNT_D: D-cache transfer in flight.
  - RESP: ready pulse to the winner.
- IDLE:
  - Sample requests. If any request is present, pick the winner and go to GNT_x.
  - At that edge, register mem_addr and mem_wdata from the winner, and set mem_read/mem_write.
  - Latency: request visible in cycle N -> mem_read/mem_write high in cycle N+1.
  - Default arbitration is fixed priority, D over I.
- GNT_x:
  - mem_* outputs held constant.
  - Requester inputs ignored; requesters hold them stable by protocol.
  - Stay until mem_ready=1 is sampled at a posedge.
  - At that edge: clear mem_read/mem_write, capture mem_rdata into x_rdata for reads, set x_ready=1, go to RESP.
- RESP (exactly 1 cycle):
  - x_ready=1, x_rdata valid.
  - Neither requester is sampled.
  - Next edge: x_ready=0, x_rdata cleared to 0, go to IDLE.
  - This guarantees the winner has dropped its request before re-arbitration.
- Memory-side deassert: mem_read/mem_write fall half a cycle before slow_memory's next negedge sample, so no spurious second transfer starts.
- D-cache read and write both high: issue a write only (mem_write=1, mem_read=0); complete with d_ready, d_rdata=0.
- D-cache write completion: d_ready pulse only; d_rdata=0.
- mem_ready in IDLE or RESP: ignored. slow_memory has no reset, so a stray pulse after rst is possible.
- Reset mid-operation:
  - Immediate return to IDLE; all outputs 0.
  - The in-flight memory transfer is abandoned; its late mem_ready arrives in IDLE and is ignored.
  - Benches hold requests low until that stray pulse has passed.
- Idle-cycle guarantee: at least one cycle (RESP) separates consecutive memory transfers. Total requester-visible latency = memory latency + 2 cycles.

Optional Feature:
- Macro: MEMARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-grant pointer updates on each grant.
  - When both ports request in IDLE, the port not granted last wins.
  - A single requester always wins.
- Undefined: fixed priority, D over I. The pointer logic is absent.

Test Plan:
- Single I read: i_read=1, i_addr=0x10, memory word block = 0x0123..CDEF -> mem_read=1 with mem_addr=0x10 one cycle later; i_ready pulses exactly 1 cycle with i_rdata=0x0123..CDEF; d_ready stays 0.
- D write then read-back: d_write=1, d_addr=0x20, d_wdata=0xA5A5..A5 -> one mem_write, one d_ready pulse. Then d_read at 0x20 -> d_rdata=0xA5A5..A5.
- Simultaneous requests, I read 0x1 and D read 0x2, both held:
  - Without MEMARB_RR_EN: D served first, then I; two d_ready/i_ready pulses in that order, exactly two mem transfers.
  - With MEMARB_RR_EN, after reset: I first, then D. Repeating the pair alternates.
- Back-to-back: requester re-asserts d_read the cycle after d_ready -> mem_read is low for at least 1 cycle between transfers; no duplicate transfer occurs.
- d_read=d_write=1, d_addr=0x30 -> mem_write=1, mem_read=0; d_ready pulse with d_rdata=0.
- Reset mid-transfer: assert rst for 1 cycle while in GNT_I -> all outputs 0 next cycle; stray mem_ready later produces no i_ready/d_ready; subsequent i_read completes normally.
